// File: rtl/coord_scaler_pipe.sv
// Two-stage coordinate scaler: S1 shifts VGA coordinates down by 1x/2x/4x and
// flags out-of-range results, S2 forms the linear framebuffer word address.
module coord_scaler_pipe #(
  parameter int IN_W   = 10,
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 17
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        MODE,
  input  logic [IN_W-1:0]   X_IN,
  input  logic [IN_W-1:0]   Y_IN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [IN_W-1:0]   X_OUT,
  output logic [IN_W-1:0]   Y_OUT,
  output logic [ADDR_W-1:0] ADDR,
  output logic              OOB,
  output logic              OUT_VALID,
  input  logic              OUT_READY
);

  logic              s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]   s1_x_q, s1_x_d;
  logic [IN_W-1:0]   s1_y_q, s1_y_d;
  logic              s1_oob_q, s1_oob_d;

  logic              s2_valid_q, s2_valid_d;
  logic [IN_W-1:0]   s2_x_q, s2_x_d;
  logic [IN_W-1:0]   s2_y_q, s2_y_d;
  logic              s2_oob_q, s2_oob_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;

  logic [1:0]        sh;
  logic [IN_W-1:0]   xs;
  logic [IN_W-1:0]   ys;
  logic              oob;
  logic              s2_load;
  logic              in_fire;

  // MODE 3 is folded onto the 4x shift
  always_comb begin
    sh  = (MODE == 2'd3) ? 2'd2 : MODE;
    xs  = X_IN >> sh;
    ys  = Y_IN >> sh;
    oob = (32'(xs) >= $unsigned(FB_W)) || (32'(ys) >= $unsigned(FB_H));
  end

  always_comb begin
    s2_load  = s1_valid_q && (!s2_valid_q || OUT_READY);
    IN_READY = !s1_valid_q || s2_load;
    in_fire  = IN_VALID && IN_READY;
  end

  always_comb begin
    s1_valid_d = in_fire ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
    s1_x_d     = in_fire ? xs  : s1_x_q;
    s1_y_d     = in_fire ? ys  : s1_y_q;
    s1_oob_d   = in_fire ? oob : s1_oob_q;
  end

  // Full-width product; the parameter rule guarantees the in-range address fits ADDR_W
  always_comb begin
    s2_valid_d = s2_load ? 1'b1 : (OUT_READY ? 1'b0 : s2_valid_q);
    s2_x_d     = s2_load ? s1_x_q   : s2_x_q;
    s2_y_d     = s2_load ? s1_y_q   : s2_y_q;
    s2_oob_d   = s2_load ? s1_oob_q : s2_oob_q;
    s2_addr_d  = s2_addr_q;
    if (s2_load) begin
      s2_addr_d = s1_oob_q ? '0 :
                  ADDR_W'(64'(s1_y_q) * 64'($unsigned(FB_W)) + 64'(s1_x_q));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_oob_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
      s2_oob_q   <= 1'b0;
      s2_addr_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_oob_q   <= s1_oob_d;
      s2_valid_q <= s2_valid_d;
      s2_x_q     <= s2_x_d;
      s2_y_q     <= s2_y_d;
      s2_oob_q   <= s2_oob_d;
      s2_addr_q  <= s2_addr_d;
    end
  end

  assign OUT_VALID = s2_valid_q;
  assign X_OUT     = s2_x_q;
  assign Y_OUT     = s2_y_q;
  assign ADDR      = s2_addr_q;
  assign OOB       = s2_oob_q;

endmodule

// File: tb/tb_coord_scaler_pipe.sv
// Bench for coord_scaler_pipe: directed tables plus randomized traffic checked
// against a queue-based model of in-flight beats.
module tb_coord_scaler_pipe;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  MODE = '0;
  logic [9:0]  X_IN = '0;
  logic [9:0]  Y_IN = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [9:0]  X_OUT;
  logic [9:0]  Y_OUT;
  logic [16:0] ADDR;
  logic        OOB;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [16:0] addr;
    logic        oob;
    int          acc;
  } beat_t;

  beat_t exp_q[$];

  coord_scaler_pipe #(.IN_W(10), .FB_W(320), .FB_H(240), .ADDR_W(17)) dut (
    .Clk(Clk), .Reset(Reset), .MODE(MODE), .X_IN(X_IN), .Y_IN(Y_IN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .X_OUT(X_OUT), .Y_OUT(Y_OUT),
    .ADDR(ADDR), .OOB(OOB), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always #5 Clk = ~Clk;

  function automatic beat_t ref_beat(int mode, int x, int y);
    beat_t b;
    int sh, xs, ys;
    sh = (mode == 3) ? 2 : mode;
    xs = x / (1 << sh);
    ys = y / (1 << sh);
    b.x    = 10'(xs);
    b.y    = 10'(ys);
    b.oob  = (xs >= 320) || (ys >= 240);
    b.addr = b.oob ? 17'd0 : 17'(ys * 320 + xs);
    b.acc  = 0;
    return b;
  endfunction

  // A beat is visible once it is at the head and has aged one cycle past acceptance
  function automatic logic exp_valid();
    return (exp_q.size() > 0) && (cyc - exp_q[0].acc >= 1);
  endfunction

  function automatic logic exp_ready();
    return (exp_q.size() < 2) || OUT_READY;
  endfunction

  task automatic advance();
    logic  inf, outf, rst;
    beat_t b;
    rst  = Reset;
    inf  = IN_VALID && exp_ready();
    outf = exp_valid() && OUT_READY;
    b    = ref_beat(int'(MODE), int'(X_IN), int'(Y_IN));
    @(posedge Clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (outf) void'(exp_q.pop_front());
      if (inf) begin
        b.acc = cyc;
        exp_q.push_back(b);
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    advance();
    advance();
    Reset = 1'b0;
    #1;
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", OUT_VALID); end
    n_cmp++;
    if ({X_OUT, Y_OUT, ADDR, OOB} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got x=%0d y=%0d addr=%0d oob=%b want all 0", X_OUT, Y_OUT, ADDR, OOB);
    end
    advance();
    #1;
    n_cmp++;
    if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", IN_READY); end
  endtask

  task automatic test_directed();
    // mode, x, y, exp_x, exp_y, exp_addr, exp_oob
    int tbl[10][7] = '{
      '{1, 639, 479, 319, 239, 76799, 0},
      '{2, 639, 479, 159, 119, 38239, 0},
      '{3,   4,   8,   1,   2,   641, 0},
      '{0, 400, 100, 400, 100,     0, 1},
      '{0, 319, 239, 319, 239, 76799, 0},
      '{0,1023,   5,1023,   5,     0, 1},
      '{0, 320,   0, 320,   0,     0, 1},
      '{1, 640,   2, 320,   1,     0, 1},
      '{0,   0, 240,   0, 240,     0, 1},
      '{2,1023,1023, 255, 255,     0, 1}
    };
    OUT_READY = 1'b1;
    for (int c = 0; c < 12; c++) begin
      IN_VALID = (c < 10);
      if (c < 10) begin
        MODE = 2'(tbl[c][0]);
        X_IN = 10'(tbl[c][1]);
        Y_IN = 10'(tbl[c][2]);
      end
      #1;
      if (c < 2) begin
        n_cmp++;
        if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL dir_fill_valid cyc=%0d got=%b want=0", c, OUT_VALID); end
      end else begin
        n_cmp++;
        if (OUT_VALID !== 1'b1) begin n_bad++; $display("FAIL dir_valid row=%0d got=%b want=1", c-2, OUT_VALID); end
        n_cmp++;
        if (X_OUT !== 10'(tbl[c-2][3]) || Y_OUT !== 10'(tbl[c-2][4])) begin
          n_bad++; $display("FAIL dir_xy row=%0d got=%0d,%0d want=%0d,%0d", c-2, X_OUT, Y_OUT, tbl[c-2][3], tbl[c-2][4]);
        end
        n_cmp++;
        if (ADDR !== 17'(tbl[c-2][5])) begin n_bad++; $display("FAIL dir_addr row=%0d got=%0d want=%0d", c-2, ADDR, tbl[c-2][5]); end
        n_cmp++;
        if (OOB !== 1'(tbl[c-2][6])) begin n_bad++; $display("FAIL dir_oob row=%0d got=%b want=%0d", c-2, OOB, tbl[c-2][6]); end
      end
      advance();
    end
    IN_VALID = 1'b0;
    advance();
  endtask

  task automatic test_stall();
    int sent = 0;
    int got = 0;
    int delivered[6];
    int want[6] = '{0, 0, 1, 1, 2, 2};
    logic saw_block = 1'b0;
    logic prev_stall = 1'b0;
    logic [9:0] px = '0, py = '0;
    logic [16:0] pa = '0;
    logic po = 1'b0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      IN_VALID  = (sent < 6);
      MODE      = 2'd1;
      X_IN      = 10'(sent);
      Y_IN      = 10'(2 * sent);
      OUT_READY = !(c >= 2 && c <= 5);
      #1;
      n_cmp++;
      if (IN_READY !== exp_ready()) begin n_bad++; $display("FAIL stall_in_ready cyc=%0d got=%b want=%b", c, IN_READY, exp_ready()); end
      if (!exp_ready()) saw_block = 1'b1;
      n_cmp++;
      if (OUT_VALID !== exp_valid()) begin n_bad++; $display("FAIL stall_out_valid cyc=%0d got=%b want=%b", c, OUT_VALID, exp_valid()); end
      if (prev_stall) begin
        n_cmp++;
        if ({X_OUT, Y_OUT, ADDR, OOB} !== {px, py, pa, po}) begin
          n_bad++; $display("FAIL stall_hold cyc=%0d got x=%0d addr=%0d want x=%0d addr=%0d", c, X_OUT, ADDR, px, pa);
        end
      end
      if (exp_valid()) begin
        n_cmp++;
        if (X_OUT !== exp_q[0].x || Y_OUT !== exp_q[0].y || ADDR !== exp_q[0].addr || OOB !== exp_q[0].oob) begin
          n_bad++; $display("FAIL stall_data cyc=%0d got x=%0d y=%0d addr=%0d want x=%0d y=%0d addr=%0d",
                            c, X_OUT, Y_OUT, ADDR, exp_q[0].x, exp_q[0].y, exp_q[0].addr);
        end
        if (OUT_READY) begin
          delivered[got] = int'(X_OUT);
          got++;
        end
      end
      prev_stall = exp_valid() && !OUT_READY;
      px = X_OUT; py = Y_OUT; pa = ADDR; po = OOB;
      if (IN_VALID && exp_ready()) sent++;
      advance();
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    n_cmp++;
    if (got != 6) begin n_bad++; $display("FAIL stall_count got=%0d want=6", got); end
    for (int i = 0; i < 6 && i < got; i++) begin
      n_cmp++;
      if (delivered[i] != want[i]) begin n_bad++; $display("FAIL stall_order idx=%0d got=%0d want=%0d", i, delivered[i], want[i]); end
    end
    n_cmp++;
    if (saw_block !== 1'b1) begin n_bad++; $display("FAIL stall_backpressure got=%b want=1", saw_block); end
    repeat (3) advance();
  endtask

  task automatic test_back_to_back();
    OUT_READY = 1'b1;
    for (int c = 0; c < 14; c++) begin
      IN_VALID = (c < 12);
      MODE = 2'($urandom_range(0, 3));
      X_IN = 10'($urandom_range(0, 1023));
      Y_IN = 10'($urandom_range(0, 1023));
      #1;
      n_cmp++;
      if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", c, IN_READY); end
      n_cmp++;
      if (OUT_VALID !== (c >= 2)) begin n_bad++; $display("FAIL b2b_out_valid cyc=%0d got=%b want=%b", c, OUT_VALID, c >= 2); end
      if (exp_valid()) begin
        n_cmp++;
        if (X_OUT !== exp_q[0].x || Y_OUT !== exp_q[0].y || ADDR !== exp_q[0].addr || OOB !== exp_q[0].oob) begin
          n_bad++; $display("FAIL b2b_data cyc=%0d got x=%0d y=%0d addr=%0d oob=%b want x=%0d y=%0d addr=%0d oob=%b",
                            c, X_OUT, Y_OUT, ADDR, OOB, exp_q[0].x, exp_q[0].y, exp_q[0].addr, exp_q[0].oob);
        end
      end
      advance();
    end
    IN_VALID = 1'b0;
    repeat (2) advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
      MODE = 2'($urandom_range(0, 3));
      X_IN = 10'($urandom_range(0, 1023));
      Y_IN = 10'($urandom_range(0, 1023));
      #1;
      n_cmp++;
      if (IN_READY !== exp_ready()) begin n_bad++; $display("FAIL rand_in_ready cyc=%0d got=%b want=%b", c, IN_READY, exp_ready()); end
      n_cmp++;
      if (OUT_VALID !== exp_valid()) begin n_bad++; $display("FAIL rand_out_valid cyc=%0d got=%b want=%b", c, OUT_VALID, exp_valid()); end
      if (exp_valid()) begin
        n_cmp++;
        if (X_OUT !== exp_q[0].x || Y_OUT !== exp_q[0].y || ADDR !== exp_q[0].addr || OOB !== exp_q[0].oob) begin
          n_bad++; $display("FAIL rand_data cyc=%0d got x=%0d y=%0d addr=%0d oob=%b want x=%0d y=%0d addr=%0d oob=%b",
                            c, X_OUT, Y_OUT, ADDR, OOB, exp_q[0].x, exp_q[0].y, exp_q[0].addr, exp_q[0].oob);
        end
      end
      advance();
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    repeat (3) advance();
  endtask

  task automatic test_mid_reset();
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    MODE = 2'd0;
    X_IN = 10'd17; Y_IN = 10'd3;
    advance();
    X_IN = 10'd18; Y_IN = 10'd4;
    advance();
    IN_VALID = 1'b0;
    #1;
    n_cmp++;
    if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
      n_bad++; $display("FAIL mid_full got valid=%b ready=%b want valid=1 ready=0", OUT_VALID, IN_READY);
    end
    Reset = 1'b1;
    advance();
    Reset = 1'b0;
    OUT_READY = 1'b1;
    #1;
    n_cmp++;
    if (OUT_VALID !== 1'b0 || ADDR !== 17'd0 || X_OUT !== 10'd0 || Y_OUT !== 10'd0 || OOB !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_out got valid=%b addr=%0d x=%0d y=%0d want all 0", OUT_VALID, ADDR, X_OUT, Y_OUT);
    end
    n_cmp++;
    if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready got=%b want=1", IN_READY); end
    for (int c = 0; c < 5; c++) begin
      advance();
      #1;
      n_cmp++;
      if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ghost cyc=%0d got valid=%b x=%0d want valid=0", c, OUT_VALID, X_OUT); end
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
